// File: rtl/vec_pkg.sv
// Shared types and helpers for the vec_gen pattern generator.
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    // Width needed to hold a popcount of 0..w inclusive.
    function automatic int pos_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Largest w-bit vector with popcount k: k ones packed at the top.
    function automatic logic [63:0] last_pattern(input int k, input int w);
        logic [63:0] ones;
        ones = (64'd1 << k) - 64'd1;
        return ones << (w - k);
    endfunction

endpackage

// File: rtl/bit_sum.sv
// Combinational population count of a DATA_W-bit word.
module bit_sum #(
    parameter int DATA_W = 10,
    parameter int POS_W  = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic [POS_W-1:0]  sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + POS_W'(data[i]);
        end
    end

endmodule

// File: rtl/vec_gen.sv
// Emits every DATA_W-bit vector with popcount K in ascending order, one per handshake.
// Optional VEC_GEN_STATS_EN adds an emitted_cnt port counting handshakes per request.
module vec_gen
    import vec_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int POS_W  = pos_width(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [POS_W-1:0]  req_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err,
`ifdef VEC_GEN_STATS_EN
    output logic [DATA_W-1:0] emitted_cnt,
`endif
    output logic              busy
);

    localparam logic [POS_W-1:0] MAX_K = POS_W'(DATA_W);

    state_t             state;
    logic [DATA_W-1:0]  cand;
    logic [POS_W-1:0]   k_reg;
    logic [POS_W-1:0]   cand_sum;
    logic [63:0]        last_full;
    logic               cand_is_last;

    bit_sum #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_bit_sum (
        .data (cand),
        .sum  (cand_sum)
    );

    assign last_full    = last_pattern(int'(k_reg), DATA_W);
    assign cand_is_last = ({{(64-DATA_W){1'b0}}, cand} == last_full);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cand        <= '0;
            k_reg       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err         <= 1'b0;
`ifdef VEC_GEN_STATS_EN
            emitted_cnt <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_count <= MAX_K) begin
                            k_reg       <= req_count;
                            cand        <= '0;
                            state       <= SCAN;
`ifdef VEC_GEN_STATS_EN
                            emitted_cnt <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (cand_sum == k_reg) begin
                        out_data  <= cand;
                        out_valid <= 1'b1;
                        out_last  <= cand_is_last;
                        state     <= EMIT;
                    end else begin
                        cand <= cand + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        // NOTE: non-blocking assignment means out_last below is still the
                        // value of the vector being handed off, even though it is cleared here.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef VEC_GEN_STATS_EN
                        emitted_cnt <= emitted_cnt + 1'b1;
`endif
                        if (out_last) begin
                            state <= IDLE;
                        end else begin
                            cand  <= cand + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_gen.sv
// Self-checking bench for vec_gen (DATA_W=4) against an enumerate-and-filter reference model.
module tb_vec_gen;

    localparam int W  = 4;
    localparam int PW = 3;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_count;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          err;
    logic          busy;
`ifdef VEC_GEN_STATS_EN
    logic [W-1:0]  emitted_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int seen[$];
    int first_lat;

    vec_gen #(.DATA_W(W), .POS_W(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_count   (req_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err         (err),
`ifdef VEC_GEN_STATS_EN
        .emitted_cnt (emitted_cnt),
`endif
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_err"},       err,       0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Drives one request and checks every cycle against the enumerated expectation.
    // abort_after > 0 returns in SCAN right after that many handshakes.
    task automatic run_request(input int k, input int stall_pct, input bit noise, input int abort_after);
        int  exp_q[$];
        int  edges;
        int  prev_c;
        int  idx;
        int  budget;
        bit  hs;
        seen.delete();
        first_lat = -1;
        @(negedge clock);
        budget = 0;
        while (!req_ready && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_count = PW'(k);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        if (k > W) begin
            check("err_pulse",     err,       1);
            check("err_busy",      busy,      0);
            check("err_req_ready", req_ready, 1);
            check("err_out_valid", out_valid, 0);
            @(negedge clock);
            check("err_clear",     err,       0);
            check("err_out_valid2", out_valid, 0);
            check("err_busy2",     busy,      0);
            return;
        end
        check("accept_busy", busy, 1);
        check("accept_req_ready", req_ready, 0);
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v) == k) exp_q.push_back(v);
        end
        idx = 0; prev_c = -1; edges = 0; budget = 0;
        while (idx < exp_q.size() && budget < 2000) begin
            check("out_valid", out_valid, (edges >= exp_q[idx] - prev_c) ? 1 : 0);
            check("err_quiet", err, 0);
            if (out_valid) begin
                if (idx == 0 && first_lat < 0) first_lat = edges;
                check("out_data", out_data, exp_q[idx]);
                check("out_last", out_last, (idx == exp_q.size() - 1) ? 1 : 0);
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            if (noise) begin
                req_valid = $urandom_range(1);
                req_count = PW'($urandom_range(7));
            end
            hs = out_valid && out_ready;
            if (hs) seen.push_back(int'(out_data));
            @(posedge clock);
            if (hs) begin
                idx++;
                prev_c = exp_q[idx-1];
                edges  = 0;
            end else begin
                edges++;
            end
            budget++;
            @(negedge clock);
            if (abort_after > 0 && idx == abort_after) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        check("no_timeout", (budget < 2000) ? 1 : 0, 1);
        check("done_out_valid", out_valid, 0);
        check("done_req_ready", req_ready, 1);
        check("done_busy",      busy,      0);
`ifdef VEC_GEN_STATS_EN
        check("emitted_cnt", emitted_cnt, exp_q.size());
`endif
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_count = '0;
        out_ready = 1'b0;
        #1;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b0;

        // Full K=2 sweep with a consumer that never stalls.
        run_request(2, 0, 1'b0, 0);
        check("k2_count", seen.size(), 6);
        if (seen.size() == 6) begin
            check("k2_first", seen[0], 4'b0011);
            check("k2_third", seen[2], 4'b0110);
            check("k2_last",  seen[5], 4'b1100);
        end

        // Boundary counts: single vector each, latency fixed by candidate index.
        run_request(0, 0, 1'b0, 0);
        check("k0_latency", first_lat, 1);
        check("k0_count", seen.size(), 1);
        if (seen.size() == 1) check("k0_vec", seen[0], 0);
        run_request(4, 0, 1'b0, 0);
        check("k4_latency", first_lat, 16);
        check("k4_count", seen.size(), 1);
        if (seen.size() == 1) check("k4_vec", seen[0], 4'b1111);

        // Out-of-range count is rejected with a single err pulse.
        run_request(5, 0, 1'b0, 0);
        run_request(7, 0, 1'b0, 0);

        // Heavy back-pressure: data must hold while stalled.
        run_request(1, 80, 1'b0, 0);
        check("k1_count", seen.size(), 4);
        if (seen.size() == 4) begin
            check("k1_v0", seen[0], 4'b0001);
            check("k1_v3", seen[3], 4'b1000);
        end

        // Reset while scanning after the second K=2 vector.
        run_request(2, 0, 1'b0, 2);
        check("abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        reset = 1'b0;
        run_request(3, 30, 1'b0, 0);
        check("k3_count", seen.size(), 4);
        if (seen.size() == 4) begin
            check("k3_v0", seen[0], 4'b0111);
            check("k3_v1", seen[1], 4'b1011);
            check("k3_v2", seen[2], 4'b1101);
            check("k3_v3", seen[3], 4'b1110);
        end

        // Randomised requests with stalls and stray requests while busy.
        for (int n = 0; n < 14; n++) begin
            run_request($urandom_range(0, 6), $urandom_range(0, 60), 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
